// File: rtl/norestore_seq_divider_pkg.sv
// Shared types for the iterative non-restoring divider: controller states and
// the step-counter width helper.
package norestore_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_e;

  // Counter must index WIDTH steps; never narrower than one bit.
  function automatic int cnt_width(input int width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/norestore_seq_divider_iter_step.sv
// One non-restoring iteration with a run-time shift: add or subtract D<<s
// depending on the sign of the partial remainder.
module norestore_iter_step #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 2
) (
  input  logic [2*WIDTH:0] r_in,
  input  logic [WIDTH-1:0] d,
  input  logic [CNT_W-1:0] s,
  output logic [2*WIDTH:0] r_out,
  output logic             q_bit
);

  logic [2*WIDTH:0] d_sh;

  always_comb begin
    d_sh  = {{(WIDTH+1){1'b0}}, d} << s;
    r_out = r_in[2*WIDTH] ? (r_in + d_sh) : (r_in - d_sh);
    q_bit = ~r_out[2*WIDTH];
  end

endmodule

// File: rtl/norestore_seq_divider.sv
// Sequential unsigned non-restoring divider: one shared add/sub step per cycle,
// MSB-first quotient, final remainder correction, valid/ready on both sides.
module norestore_seq_divider
  import norestore_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = cnt_width(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_zero
);

  localparam logic [CNT_W-1:0] LAST_K = CNT_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [2*WIDTH:0] r_q, r_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [CNT_W-1:0] k_q, k_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             div_zero_q, div_zero_d;
  logic             out_valid_q, out_valid_d;

  logic [CNT_W-1:0] step_s;
  logic [2*WIDTH:0] step_r;
  logic             step_q;
  logic [2*WIDTH:0] r_fix;

  // Shift runs from WIDTH-1 down to 0 as k counts up.
  assign step_s = LAST_K - k_q;

  norestore_iter_step #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_step (
    .r_in  (r_q),
    .d     (d_q),
    .s     (step_s),
    .r_out (step_r),
    .q_bit (step_q)
  );

  always_comb begin
    state_d     = state_q;
    r_d         = r_q;
    d_d         = d_q;
    q_d         = q_q;
    k_d         = k_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    div_zero_d  = div_zero_q;
    out_valid_d = out_valid_q;
    r_fix       = r_q[2*WIDTH] ? (r_q + {{(WIDTH+1){1'b0}}, d_q}) : r_q;

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          d_d        = divisor;
          r_d        = {{(WIDTH+1){1'b0}}, dividend};
          q_d        = '0;
          div_zero_d = 1'b0;
          if (divisor != '0) begin
            k_d     = '0;
            state_d = CALC;
          end else begin
            // Divide-by-zero skips iteration and returns all-ones / dividend.
            quotient_d  = '1;
            remainder_d = dividend;
            div_zero_d  = 1'b1;
            out_valid_d = 1'b1;
            state_d     = DONE;
          end
        end
      end
      CALC: begin
        r_d = step_r;
        q_d = {q_q[WIDTH-2:0], step_q};
        if (k_q == LAST_K) begin
          state_d = FIX;
        end else begin
          k_d = k_q + CNT_W'(1);
        end
      end
      FIX: begin
        r_d         = r_fix;
        quotient_d  = q_q;
        remainder_d = r_fix[WIDTH-1:0];
        out_valid_d = 1'b1;
        state_d     = DONE;
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      r_q         <= '0;
      d_q         <= '0;
      q_q         <= '0;
      k_q         <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      div_zero_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      r_q         <= r_d;
      d_q         <= d_d;
      q_q         <= q_d;
      k_q         <= k_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      div_zero_q  <= div_zero_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = out_valid_q;
  assign quotient  = quotient_q;
  assign remainder = remainder_q;
  assign div_zero  = div_zero_q;

endmodule

// File: tb/tb_norestore_seq_divider.sv
// Directed and sweep checks for the sequential non-restoring divider (WIDTH=4).
module tb_norestore_seq_divider;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_zero;

  int total = 0;
  int bad   = 0;

  norestore_seq_divider #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .dividend  (dividend),
    .divisor   (divisor),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .quotient  (quotient),
    .remainder (remainder),
    .div_zero  (div_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Called at a negedge: presents operands, waits for in_ready, accepts at posedge.
  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, output int waited);
    waited   = 0;
    in_valid = 1'b1;
    dividend = a;
    divisor  = b;
    while (!in_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    chk("in_ready_wait", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  // Called just after the accepting edge; ends at a negedge with DUT back in IDLE.
  task automatic finish_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                           input int hold, input logic [W-1:0] eq, input logic [W-1:0] er,
                           input logic ez, input int exp_lat);
    int lat;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (!out_valid) chk({tag, "_busy_in_ready"}, {31'd0, in_ready}, 32'd0);
    end while (!out_valid && lat < 20);
    chk({tag, "_out_valid"}, {31'd0, out_valid}, 32'd1);
    if (!out_valid) return;
    chk({tag, "_latency"}, lat, exp_lat);
    chk({tag, "_in_ready_done"}, {31'd0, in_ready}, 32'd0);
    chk({tag, "_quotient"}, {28'd0, quotient}, {28'd0, eq});
    chk({tag, "_remainder"}, {28'd0, remainder}, {28'd0, er});
    chk({tag, "_div_zero"}, {31'd0, div_zero}, {31'd0, ez});
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk({tag, "_hold_valid"}, {31'd0, out_valid}, 32'd1);
      chk({tag, "_hold_q"}, {28'd0, quotient}, {28'd0, eq});
      chk({tag, "_hold_r"}, {28'd0, remainder}, {28'd0, er});
      chk({tag, "_hold_ready"}, {31'd0, in_ready}, 32'd0);
    end
    $display("op %s: %0d/%0d -> q=%0d r=%0d dz=%0d lat=%0d hold=%0d",
             tag, a, b, quotient, remainder, div_zero, lat, hold);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    chk({tag, "_after_valid"}, {31'd0, out_valid}, 32'd0);
    chk({tag, "_after_ready"}, {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    int wt;
    logic [W-1:0] eq, er;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    dividend  = '0;
    divisor   = '0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_quotient", {28'd0, quotient}, 32'd0);
    chk("rst_remainder", {28'd0, remainder}, 32'd0);
    chk("rst_div_zero", {31'd0, div_zero}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // 13/3: R -11, 1, -5, -2 -> corrected to 1, quotient 0100
    start_op(4'd13, 4'd3, wt);
    finish_op("d13_3", 4'd13, 4'd3, 0, 4'd4, 4'd1, 1'b0, 6);

    // Back-to-back with the producer holding in_valid through the first op
    start_op(4'd15, 4'd1, wt);
    in_valid = 1'b1;
    dividend = 4'd2;
    divisor  = 4'd7;
    finish_op("d15_1", 4'd15, 4'd1, 0, 4'd15, 4'd0, 1'b0, 6);
    start_op(4'd2, 4'd7, wt);
    chk("b2b_accept_wait", wt, 0);
    finish_op("d2_7", 4'd2, 4'd7, 0, 4'd0, 4'd2, 1'b0, 6);

    // Divide by zero, then an ordinary op clears div_zero
    start_op(4'd9, 4'd0, wt);
    finish_op("d9_0", 4'd9, 4'd0, 0, 4'd15, 4'd9, 1'b1, 1);
    start_op(4'd8, 4'd2, wt);
    finish_op("d8_2", 4'd8, 4'd2, 0, 4'd4, 4'd0, 1'b0, 6);

    // Consumer stalls three cycles
    start_op(4'd14, 4'd5, wt);
    finish_op("d14_5", 4'd14, 4'd5, 3, 4'd2, 4'd4, 1'b0, 6);

    // Reset during CALC step k=2 aborts the operation
    start_op(4'd12, 4'd5, wt);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    chk("abort_out_valid", {31'd0, out_valid}, 32'd0);
    chk("abort_in_ready", {31'd0, in_ready}, 32'd1);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("abort_no_result", {31'd0, out_valid}, 32'd0);
    end
    start_op(4'd12, 4'd5, wt);
    finish_op("d12_5", 4'd12, 4'd5, 0, 4'd2, 4'd2, 1'b0, 6);

    // Full sweep with random consumer stalls
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        if (b == 0) begin
          eq = 4'd15;
          er = W'(a);
        end else begin
          eq = W'(a / b);
          er = W'(a % b);
        end
        start_op(W'(a), W'(b), wt);
        finish_op("sweep", W'(a), W'(b), int'($urandom_range(0, 2)), eq, er,
                  (b == 0), (b == 0) ? 1 : 6);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout got=0 exp=1");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/norestore_seq_divider.md
Name: norestore_seq_divider

Overview:
- Iterative unsigned non-restoring divider: one add/sub datapath reused across WIDTH cycles instead of a WIDTH-stage cell array.
- Controller accepts an operand pair via valid/ready and sequences the datapath one quotient bit per cycle, MSB first.
- Applies the final remainder correction and returns quotient/remainder via valid/ready.
- Sits beside the combinational array divider as the area-optimised variant.

Parameters:
- WIDTH, 4, dividend/divisor/quotient/remainder width (>=2).
- CNT_W, $clog2(WIDTH), step counter width (derived; not overridden).

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  synchronous active-low reset.
- in_valid  input  1  operand pair valid.
- in_ready  output  1  block can accept; high only in IDLE.
- dividend  input  WIDTH  unsigned dividend.
- divisor  input  WIDTH  unsigned divisor.
- out_valid  output  1  result valid; held until out_ready.
- out_ready  input  1  consumer accepts result.
- quotient  output  WIDTH  unsigned quotient.
- remainder  output  WIDTH  unsigned remainder.
- div_zero  output  1  result came from divisor==0.

Behaviour:
- Reset (rst_n low at clk edge): state=IDLE, out_valid=0, quotient=0, remainder=0, div_zero=0, counter=0, internal remainder R=0. Reset mid-operation aborts; the in-flight result is discarded and never presented.
- Internal state: R is 2*WIDTH+1 bits two's complement; D is the latched divisor; Q is the quotient shift register; k is the step counter.
- FSM states: IDLE, CALC, FIX, DONE.
- IDLE: in_ready=1. On in_valid, latch D=divisor and R={0, dividend} zero-extended; clear Q and div_zero.
  - If divisor!=0: k=0, go to CALC.
  - If divisor==0: quotient={WIDTH{1}}, remainder=dividend, div_zero=1, go to DONE.
- CALC, one step per cycle, shift s=WIDTH-1-k:
  - Dsh = D<<s, zero-extended to 2*WIDTH+1 bits.
  - If R[2W]==0, R <= R-Dsh; otherwise R <= R+Dsh. Arithmetic is modulo 2^(2W+1); no overflow is possible.
  - Q <= {Q[W-2:0], ~Rnew[2W]}.
  - When k==WIDTH-1, go to FIX; otherwise k++.
- FIX: if R[2W]==1, R+=D. Register quotient=Q and remainder=low WIDTH bits of corrected R. Go to DONE.
- DONE: out_valid=1 with outputs stable until the out_ready handshake completes; then go to IDLE (out_valid=0 next cycle).
  - No new accept in the same cycle as result handoff; in_ready rises the cycle after.
- Latency: out_valid is high WIDTH+2 cycles after the accepting edge; divide-by-zero results appear 1 cycle after it.
- Throughput: one operation per WIDTH+3 cycles with out_ready held high.
- in_valid while busy is ignored; in_ready=0 is the backpressure signal, and the producer must hold its operands.
- Outputs (quotient, remainder, div_zero) hold their last values in IDLE and CALC; only out_valid qualifies them.
- All outputs are registered; in_ready decodes directly from state.

Decomposition:
- Package norestore_pkg: state enum (IDLE, CALC, FIX, DONE, 2-bit encoding); function for counter width.
- One natural sub-module: norestore_iter_step (combinational).
  - Inputs: R (2W+1), D (W), s (CNT_W).
  - Outputs: next R, quotient bit.
  - Sign-selected add/sub of D<<s.
- The fixed-STEP norestore_cell cannot be reused here because the shift varies at run time.

Test Plan (WIDTH=4):
- 13/3 accepted at cycle 0 -> R trace -11, 1, -5, -2; out_valid at cycle 6 with quotient=4, remainder=1, div_zero=0.
- 15/1 and 2/7 back-to-back, producer holding in_valid -> (15,0) then (0,2); second accept occurs the cycle after the first out handshake; in_ready=0 throughout the first op.
- 9/0 -> out_valid 1 cycle after accept with quotient=15, remainder=9, div_zero=1; next op 8/2 -> (4,0), div_zero=0.
- 14/5 with out_ready low for 3 cycles after out_valid -> out_valid and outputs (2,4) held constant; single handshake; then IDLE.
- rst_n low during CALC step k=2 of 12/5, then release -> next cycle state=IDLE, out_valid=0, in_ready=1; a fresh 12/5 gives (2,2).
- Exhaustive sweep: all 256 dividend/divisor pairs with random out_ready -> results match dividend/divisor and dividend%divisor, plus the div-zero rule.
